mram_ctrl: RTL and testbench
============================

# mram_ctrl

Main-RAM initiator for the FM-7 core. It owns the requesting side of the main RAM interface: it drives address, write data, write strobe and read strobe into the main RAM block, and captures its registered read data. It arbitrates between single-byte CPU accesses and display read bursts, with round-robin tie-break, a pipelined read-capture path, and a one-deep pending latch per requester.

## Interface
- RD_LAT, 1, cycles from a read-strobed address edge to valid DOUT (1 or 2).
- CLKSYS  in  1  system clock; all state changes on the rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- CPU_REQ  in  1  single-cycle access request pulse; ignored while CPU_BUSY=1.
- CPU_WE  in  1  1 = write, 0 = read; sampled with CPU_REQ.
- CPU_ADDR  in  16  byte address; sampled with CPU_REQ.
- CPU_WDATA  in  8  write data; sampled with CPU_REQ.
- CPU_BUSY  out  1  high from the cycle after an accepted REQ through the CPU_ACK cycle.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  8  read data; valid with CPU_ACK on reads, held until the next read.
- VID_REQ  in  1  burst request pulse; ignored while VID_BUSY=1.
- VID_ADDR  in  16  burst start address.
- VID_LEN  in  8  beat count; 0 encodes 256.
- VID_BUSY  out  1  high from acceptance through the VID_DONE cycle.
- VID_VALID  out  1  one pulse per returned beat.
- VID_DATA  out  8  beat data, valid with VID_VALID.
- VID_DONE  out  1  high with the VID_VALID of the last beat.
- MADDRBUS  out  16  RAM address.
- DIN  out  8  RAM write data.
- RWBn  out  1  RAM write enable, active-high.
- RDQEn  out  1  RAM read enable, active-high.
- DOUT  in  8  RAM read data.

## Operation
- Pending latches:
  - An accepted CPU_REQ or VID_REQ stores its operands in that requester's latch and sets BUSY.
  - A latch clears when its access is granted.
- States: IDLE, CWR, CRD, VRD.
- IDLE:
  - Candidates are the pending latches and REQ inputs asserted this cycle.
  - If only one candidate exists, it is granted.
  - If both exist, the requester not granted last wins. last_grant resets to CPU, so video wins the first tie.
  - With no candidate, remain in IDLE.
- CWR (1 cycle):
  - Drive MADDRBUS, DIN and RWBn=1; RDQEn=0.
  - Go to IDLE.
- CRD (1 cycle):
  - Drive MADDRBUS and RDQEn=1.
  - Push tag {dest=CPU, last=0} into the capture pipe.
  - Go to IDLE.
- VRD (L cycles):
  - Drive RDQEn=1 and the address, incrementing by 1 each cycle. Addresses wrap 0xFFFF→0x0000.
  - An 8-bit down-counter counts beats. Each beat pushes {dest=VID, last=(final beat)}.
  - After the final beat, go to IDLE.
- Outside CWR, CRD and VRD, RWBn=0 and RDQEn=0. MADDRBUS and DIN hold their last values.
- Capture pipe:
  - The pipe is RD_LAT+1 deep and independent of the FSM, so a new grant may proceed while reads are in flight.
  - At the stage where DOUT is valid, DOUT is registered into CPU_RDATA or VID_DATA according to the tag. The next cycle raises CPU_ACK, or VID_VALID (plus VID_DONE if last=1).
- CPU write completion: CPU_ACK is generated directly in the cycle after CWR and does not go through the pipe.
- RWBn and RDQEn are never high together.
- Reset (asynchronous, any time including mid-burst):
  - All outputs are 0: MADDRBUS=0, DIN=0, RWBn=0, RDQEn=0, CPU_ACK=0, CPU_RDATA=0, VID_VALID=0, VID_DATA=0, VID_DONE=0, CPU_BUSY=0, VID_BUSY=0.
  - Latches and the pipe are cleared. In-flight beats are discarded with no partial DONE.
  - State returns to IDLE and last_grant to CPU.

## Timing
Cycle n is the cycle in which REQ is high, or the IDLE cycle in which the pending request wins.
- Granted requests:
  - CPU write: CWR in n+1; RAM writes at the end of n+1; CPU_ACK in n+2; CPU_BUSY drops after n+2.
  - CPU read: CRD in n+1; DOUT valid in n+1+RD_LAT; CPU_ACK and CPU_RDATA in n+2+RD_LAT.
  - Video burst: beat i (0..L-1) has its address in cycle n+1+i; VID_VALID in n+2+RD_LAT+i; VID_DONE in n+1+RD_LAT+L.
- Bus sharing:
  - There is at least one IDLE cycle between any two grants.
  - A CPU request arriving during a burst waits until the burst's last address cycle plus one IDLE cycle. It is then granted, because last_grant=VID.
- Request filtering:
  - CPU_REQ and VID_REQ in the same IDLE cycle are both accepted; the loser stays pending.
  - REQ while the matching BUSY=1 has no effect and must not corrupt the latch.

## Test plan
- **CPU write then read:** write 0x5A to 0x1234, then read 0x1234 → RWBn high for exactly 1 cycle with MADDRBUS=0x1234 and DIN=0x5A; CPU_ACK in n+2; read CPU_ACK in n+3 (RD_LAT=1) with CPU_RDATA=0x5A.
- **Wrapping burst:** RAM preloaded with data = low address byte; burst ADDR=0xFFFE, LEN=4 → MADDRBUS sequence FFFE, FFFF, 0000, 0001; VID_DATA FE, FF, 00, 01 on consecutive VID_VALID; VID_DONE only on the 4th beat.
- **Simultaneous requests after reset:** CPU_REQ and VID_REQ (LEN=2) in the same cycle → video granted first. The CPU read is granted after the burst plus 1 IDLE cycle. All data is correct with no RWBn/RDQEn overlap.
- **Ignored and full-length requests:** CPU_REQ during CPU_BUSY with different ADDR → ignored, and the original access completes unchanged. VID_LEN=0 → exactly 256 VID_VALID pulses.
- **Reset mid-burst:** assert RSTn=0 at beat 3 of a LEN=8 burst → all outputs 0 immediately. After release: no VID_VALID or VID_DONE, and BUSY=0.
- **RD_LAT=2 build:** repeat the CPU read → CPU_ACK in n+4 with correct data.

Source files
------------

// File: rtl/mram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// mram_ctrl : FM-7 main-RAM initiator, CPU/video arbitration, pipelined capture
// Rev 1.0
//==============================================================================
module mram_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        CLKSYS,
    input  logic        RSTn,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_WDATA,
    output logic        CPU_BUSY,
    output logic        CPU_ACK,
    output logic [7:0]  CPU_RDATA,
    input  logic        VID_REQ,
    input  logic [15:0] VID_ADDR,
    input  logic [7:0]  VID_LEN,
    output logic        VID_BUSY,
    output logic        VID_VALID,
    output logic [7:0]  VID_DATA,
    output logic        VID_DONE,
    output logic [15:0] MADDRBUS,
    output logic [7:0]  DIN,
    output logic        RWBn,
    output logic        RDQEn,
    input  logic [7:0]  DOUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CWR  = 2'd1,
        S_CRD  = 2'd2,
        S_VRD  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_vid;
    logic [7:0]      r_beats;
    logic [15:0]     r_maddr;
    logic [7:0]      r_din;
    logic            r_rwbn;
    logic            r_rdqen;

    logic            r_push_v;
    logic            r_push_vid;
    logic            r_push_last;
    logic [RD_LAT:1] r_tv_v;
    logic [RD_LAT:1] r_tv_vid;
    logic [RD_LAT:1] r_tv_last;

    logic            r_cpu_pend;
    logic            r_cpu_we;
    logic [15:0]     r_cpu_addr;
    logic [7:0]      r_cpu_wdata;
    logic            r_cpu_busy;
    logic            r_cpu_ack;
    logic [7:0]      r_cpu_rdata;

    logic            r_vid_pend;
    logic [15:0]     r_vid_addr;
    logic [7:0]      r_vid_len;
    logic            r_vid_busy;
    logic            r_vid_valid;
    logic            r_vid_done;
    logic [7:0]      r_vid_data;

    logic            w_cpu_acc;
    logic            w_vid_acc;
    logic            w_cpu_cand;
    logic            w_vid_cand;
    logic            w_idle;
    logic            w_grant_cpu;
    logic            w_grant_vid;
    logic            w_cpu_we;
    logic [15:0]     w_cpu_addr;
    logic [7:0]      w_cpu_wdata;
    logic [15:0]     w_vid_addr;
    logic [7:0]      w_vid_len;

    // A request arriving in an IDLE cycle competes immediately, so operands
    // come straight from the ports when nothing is latched yet.
    assign w_cpu_acc   = CPU_REQ & ~r_cpu_busy;
    assign w_vid_acc   = VID_REQ & ~r_vid_busy;
    assign w_cpu_cand  = r_cpu_pend | w_cpu_acc;
    assign w_vid_cand  = r_vid_pend | w_vid_acc;
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_vid = w_idle & w_vid_cand & (~w_cpu_cand | ~r_last_vid);
    assign w_grant_cpu = w_idle & w_cpu_cand & ~w_grant_vid;

    assign w_cpu_we    = r_cpu_pend ? r_cpu_we    : CPU_WE;
    assign w_cpu_addr  = r_cpu_pend ? r_cpu_addr  : CPU_ADDR;
    assign w_cpu_wdata = r_cpu_pend ? r_cpu_wdata : CPU_WDATA;
    assign w_vid_addr  = r_vid_pend ? r_vid_addr  : VID_ADDR;
    assign w_vid_len   = r_vid_pend ? r_vid_len   : VID_LEN;

    always_ff @(posedge CLKSYS or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_last_vid  <= 1'b0;
            r_beats     <= 8'd0;
            r_maddr     <= 16'd0;
            r_din       <= 8'd0;
            r_rwbn      <= 1'b0;
            r_rdqen     <= 1'b0;
            r_push_v    <= 1'b0;
            r_push_vid  <= 1'b0;
            r_push_last <= 1'b0;
        end else begin
            r_rwbn      <= 1'b0;
            r_rdqen     <= 1'b0;
            r_push_v    <= 1'b0;
            r_push_vid  <= 1'b0;
            r_push_last <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vid) begin
                        r_state     <= S_VRD;
                        r_last_vid  <= 1'b1;
                        r_maddr     <= w_vid_addr;
                        r_rdqen     <= 1'b1;
                        // Length 0 underflows to 255 remaining, giving 256 beats
                        r_beats     <= w_vid_len - 8'd1;
                        r_push_v    <= 1'b1;
                        r_push_vid  <= 1'b1;
                        r_push_last <= (w_vid_len == 8'd1);
                    end else if (w_grant_cpu) begin
                        r_last_vid <= 1'b0;
                        r_maddr    <= w_cpu_addr;
                        if (w_cpu_we) begin
                            r_state <= S_CWR;
                            r_din   <= w_cpu_wdata;
                            r_rwbn  <= 1'b1;
                        end else begin
                            r_state  <= S_CRD;
                            r_rdqen  <= 1'b1;
                            r_push_v <= 1'b1;
                        end
                    end
                end
                S_CWR: r_state <= S_IDLE;
                S_CRD: r_state <= S_IDLE;
                S_VRD: begin
                    if (r_beats == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_maddr     <= r_maddr + 16'd1;
                        r_rdqen     <= 1'b1;
                        r_beats     <= r_beats - 8'd1;
                        r_push_v    <= 1'b1;
                        r_push_vid  <= 1'b1;
                        r_push_last <= (r_beats == 8'd1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag pipe: stage k holds the tag of the address issued k cycles ago, so
    // stage RD_LAT lines up with valid DOUT.
    always_ff @(posedge CLKSYS or negedge RSTn) begin
        if (!RSTn) begin
            r_tv_v    <= '0;
            r_tv_vid  <= '0;
            r_tv_last <= '0;
        end else begin
            r_tv_v[1]    <= r_push_v;
            r_tv_vid[1]  <= r_push_vid;
            r_tv_last[1] <= r_push_last;
            for (int j = 2; j <= RD_LAT; j++) begin
                r_tv_v[j]    <= r_tv_v[j-1];
                r_tv_vid[j]  <= r_tv_vid[j-1];
                r_tv_last[j] <= r_tv_last[j-1];
            end
        end
    end

    always_ff @(posedge CLKSYS or negedge RSTn) begin
        if (!RSTn) begin
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= 8'd0;
            r_vid_valid <= 1'b0;
            r_vid_done  <= 1'b0;
            r_vid_data  <= 8'd0;
        end else begin
            r_cpu_ack   <= (r_state == S_CWR);
            r_vid_valid <= 1'b0;
            r_vid_done  <= 1'b0;
            if (r_tv_v[RD_LAT]) begin
                if (r_tv_vid[RD_LAT]) begin
                    r_vid_data  <= DOUT;
                    r_vid_valid <= 1'b1;
                    r_vid_done  <= r_tv_last[RD_LAT];
                end else begin
                    r_cpu_rdata <= DOUT;
                    r_cpu_ack   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLKSYS or negedge RSTn) begin
        if (!RSTn) begin
            r_cpu_pend  <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= 16'd0;
            r_cpu_wdata <= 8'd0;
            r_cpu_busy  <= 1'b0;
            r_vid_pend  <= 1'b0;
            r_vid_addr  <= 16'd0;
            r_vid_len   <= 8'd0;
            r_vid_busy  <= 1'b0;
        end else begin
            if (w_grant_cpu) begin
                r_cpu_pend <= 1'b0;
            end else if (w_cpu_acc) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_we    <= CPU_WE;
                r_cpu_addr  <= CPU_ADDR;
                r_cpu_wdata <= CPU_WDATA;
            end
            if (w_cpu_acc) begin
                r_cpu_busy <= 1'b1;
            end else if (r_cpu_ack) begin
                r_cpu_busy <= 1'b0;
            end

            if (w_grant_vid) begin
                r_vid_pend <= 1'b0;
            end else if (w_vid_acc) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= VID_ADDR;
                r_vid_len  <= VID_LEN;
            end
            if (w_vid_acc) begin
                r_vid_busy <= 1'b1;
            end else if (r_vid_done) begin
                r_vid_busy <= 1'b0;
            end
        end
    end

    assign CPU_BUSY  = r_cpu_busy;
    assign CPU_ACK   = r_cpu_ack;
    assign CPU_RDATA = r_cpu_rdata;
    assign VID_BUSY  = r_vid_busy;
    assign VID_VALID = r_vid_valid;
    assign VID_DATA  = r_vid_data;
    assign VID_DONE  = r_vid_done;
    assign MADDRBUS  = r_maddr;
    assign DIN       = r_din;
    assign RWBn      = r_rwbn;
    assign RDQEn     = r_rdqen;

endmodule
`default_nettype wire

// File: tb/tb_mram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_mram_ctrl : directed bench for mram_ctrl (RD_LAT=1 and RD_LAT=2 instances)
// Rev 1.0
//==============================================================================
module tb_mram_ctrl;

    logic        CLKSYS;
    logic        RSTn;

    logic        cpu_req, cpu_we, cpu_busy, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        vid_req, vid_busy, vid_valid, vid_done;
    logic [15:0] vid_addr;
    logic [7:0]  vid_len, vid_data;
    logic [15:0] maddr;
    logic [7:0]  din, dout;
    logic        rwbn, rdqen;

    logic        c2_req, c2_we, c2_busy, c2_ack;
    logic [15:0] c2_addr;
    logic [7:0]  c2_wdata, c2_rdata;
    logic        v2_req, v2_busy, v2_valid, v2_done;
    logic [15:0] v2_addr;
    logic [7:0]  v2_len, v2_data;
    logic [15:0] maddr2;
    logic [7:0]  din2, dout2, rs2;
    logic        rwbn2, rdqen2;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;
    int done_orphan = 0;

    int          wr_cyc[$];
    logic [15:0] wr_addr[$];
    logic [7:0]  wr_din[$];
    int          rd_cyc[$];
    logic [15:0] rd_addr[$];
    int          ack_cyc[$];
    logic [7:0]  ack_dat[$];
    int          vv_cyc[$];
    logic [7:0]  vv_dat[$];
    logic        vv_done[$];
    int          ack2_cyc[$];
    logic [7:0]  ack2_dat[$];

    logic [7:0]  mem1 [0:65535];
    bit          wm1  [0:65535];
    logic [7:0]  mem2 [0:65535];
    bit          wm2  [0:65535];

    mram_ctrl #(.RD_LAT(1)) u_dut (
        .CLKSYS(CLKSYS), .RSTn(RSTn),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_BUSY(cpu_busy), .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
        .VID_REQ(vid_req), .VID_ADDR(vid_addr), .VID_LEN(vid_len),
        .VID_BUSY(vid_busy), .VID_VALID(vid_valid), .VID_DATA(vid_data), .VID_DONE(vid_done),
        .MADDRBUS(maddr), .DIN(din), .RWBn(rwbn), .RDQEn(rdqen), .DOUT(dout)
    );

    mram_ctrl #(.RD_LAT(2)) u_dut2 (
        .CLKSYS(CLKSYS), .RSTn(RSTn),
        .CPU_REQ(c2_req), .CPU_WE(c2_we), .CPU_ADDR(c2_addr), .CPU_WDATA(c2_wdata),
        .CPU_BUSY(c2_busy), .CPU_ACK(c2_ack), .CPU_RDATA(c2_rdata),
        .VID_REQ(v2_req), .VID_ADDR(v2_addr), .VID_LEN(v2_len),
        .VID_BUSY(v2_busy), .VID_VALID(v2_valid), .VID_DATA(v2_data), .VID_DONE(v2_done),
        .MADDRBUS(maddr2), .DIN(din2), .RWBn(rwbn2), .RDQEn(rdqen2), .DOUT(dout2)
    );

    initial CLKSYS = 1'b0;
    always #5 CLKSYS = ~CLKSYS;

    always @(posedge CLKSYS) cyc <= cyc + 1;

    // Unwritten RAM locations read back as their low address byte.
    function automatic logic [7:0] rd1(input logic [15:0] a);
        return wm1[a] ? mem1[a] : a[7:0];
    endfunction
    function automatic logic [7:0] rd2(input logic [15:0] a);
        return wm2[a] ? mem2[a] : a[7:0];
    endfunction

    always @(posedge CLKSYS) begin
        if (rwbn) begin
            mem1[maddr] <= din;
            wm1[maddr]  <= 1'b1;
        end
        if (rdqen) dout <= rd1(maddr);
    end

    always @(posedge CLKSYS) begin
        if (rwbn2) begin
            mem2[maddr2] <= din2;
            wm2[maddr2]  <= 1'b1;
        end
        if (rdqen2) rs2 <= rd2(maddr2);
        dout2 <= rs2;
    end

    always @(negedge CLKSYS) begin
        if ((rwbn && rdqen) || (rwbn2 && rdqen2)) overlap++;
        if (vid_done && !vid_valid) done_orphan++;
        if (rwbn) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(maddr);
            wr_din.push_back(din);
        end
        if (rdqen) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(maddr);
        end
        if (cpu_ack) begin
            ack_cyc.push_back(cyc);
            ack_dat.push_back(cpu_rdata);
        end
        if (vid_valid) begin
            vv_cyc.push_back(cyc);
            vv_dat.push_back(vid_data);
            vv_done.push_back(vid_done);
        end
        if (c2_ack) begin
            ack2_cyc.push_back(cyc);
            ack2_dat.push_back(c2_rdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLKSYS);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_addr.delete(); wr_din.delete();
        rd_cyc.delete(); rd_addr.delete();
        ack_cyc.delete(); ack_dat.delete();
        vv_cyc.delete(); vv_dat.delete(); vv_done.delete();
        ack2_cyc.delete(); ack2_dat.delete();
        done_orphan = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] exp_a [0:3];
    logic [7:0]  exp_d [0:3];
    logic [3:0]  df;
    int          n, errs, ndone;

    initial begin
        RSTn = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0; vid_len = 0;
        c2_req = 0; c2_we = 0; c2_addr = 0; c2_wdata = 0;
        v2_req = 0; v2_addr = 0; v2_len = 0;
        tick(3);
        chk("rst_maddr", maddr, 0);
        chk("rst_ctl", {rwbn, rdqen, cpu_ack, vid_valid, vid_done, cpu_busy, vid_busy}, 0);
        chk("rst_data", {din, cpu_rdata, vid_data}, 0);
        RSTn = 1'b1;
        tick(2);

        // CPU write 0x5A to 0x1234
        clear_logs();
        n = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
        tick(1);
        cpu_req = 0;
        chk("wr_busy", cpu_busy, 1);
        tick(4);
        chk("wr_count", wr_cyc.size(), 1);
        if (wr_cyc.size() > 0) begin
            chk("wr_cycle", wr_cyc[0], n + 1);
            chk("wr_addr", wr_addr[0], 16'h1234);
            chk("wr_din", wr_din[0], 8'h5A);
        end
        chk("wr_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) chk("wr_ack_cycle", ack_cyc[0], n + 2);
        chk("wr_busy_drop", cpu_busy, 0);

        // CPU read back 0x1234
        clear_logs();
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        tick(1);
        cpu_req = 0;
        tick(5);
        chk("rd_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) begin
            chk("rd_ack_cycle", ack_cyc[0], n + 3);
            chk("rd_data", ack_dat[0], 8'h5A);
        end
        chk("rd_no_write", wr_cyc.size(), 0);

        // Wrapping burst from 0xFFFE, length 4
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        clear_logs();
        n = cyc;
        vid_req = 1; vid_addr = 16'hFFFE; vid_len = 8'd4;
        tick(1);
        vid_req = 0;
        tick(9);
        chk("wrap_addr_count", rd_addr.size(), 4);
        chk("wrap_beat_count", vv_dat.size(), 4);
        df = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (rd_addr.size() > i) begin
                chk($sformatf("wrap_addr%0d", i), rd_addr[i], exp_a[i]);
                chk($sformatf("wrap_acyc%0d", i), rd_cyc[i], n + 1 + i);
            end
            if (vv_dat.size() > i) begin
                chk($sformatf("wrap_data%0d", i), vv_dat[i], exp_d[i]);
                chk($sformatf("wrap_vcyc%0d", i), vv_cyc[i], n + 3 + i);
                df[i] = vv_done[i];
            end
        end
        chk("wrap_done_flags", df, 4'b1000);
        chk("wrap_busy_drop", vid_busy, 0);

        // Simultaneous requests right after reset: video wins the tie
        RSTn = 1'b0;
        tick(2);
        RSTn = 1'b1;
        tick(2);
        clear_logs();
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        vid_req = 1; vid_addr = 16'h0020; vid_len = 8'd2;
        tick(1);
        cpu_req = 0; vid_req = 0;
        chk("sim_cpu_pending_busy", cpu_busy, 1);
        tick(8);
        chk("sim_addr_count", rd_addr.size(), 3);
        if (rd_addr.size() > 2) begin
            chk("sim_addr0", rd_addr[0], 16'h0020);
            chk("sim_addr1", rd_addr[1], 16'h0021);
            chk("sim_addr2", rd_addr[2], 16'h0010);
            chk("sim_cpu_cycle", rd_cyc[2], n + 4);
        end
        chk("sim_beats", vv_dat.size(), 2);
        if (vv_dat.size() > 1) begin
            chk("sim_vdata0", vv_dat[0], 8'h20);
            chk("sim_vdata1", vv_dat[1], 8'h21);
            chk("sim_vdone", {vv_done[1], vv_done[0]}, 2'b10);
            chk("sim_vcyc1", vv_cyc[1], n + 4);
        end
        chk("sim_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) begin
            chk("sim_ack_cycle", ack_cyc[0], n + 6);
            chk("sim_cpu_data", ack_dat[0], 8'h10);
        end

        // CPU_REQ while busy is ignored
        clear_logs();
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        tick(1);
        cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 8'hEE;
        tick(1);
        cpu_req = 0;
        tick(6);
        chk("ign_ack_count", ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) begin
            chk("ign_ack_cycle", ack_cyc[0], n + 3);
            chk("ign_data", ack_dat[0], 8'h40);
        end
        chk("ign_no_write", wr_cyc.size(), 0);
        chk("ign_mem_untouched", wm1[16'h0050], 0);
        chk("ign_busy_drop", cpu_busy, 0);

        // Full-length burst: VID_LEN=0 means 256 beats
        clear_logs();
        vid_req = 1; vid_addr = 16'h0100; vid_len = 8'd0;
        tick(1);
        vid_req = 0;
        tick(265);
        chk("full_beats", vv_dat.size(), 256);
        chk("full_addrs", rd_addr.size(), 256);
        errs = 0;
        ndone = 0;
        foreach (vv_dat[i]) begin
            if (vv_dat[i] !== 8'(i)) errs++;
            if (vv_done[i]) ndone++;
        end
        chk("full_data_errs", errs, 0);
        chk("full_done_count", ndone, 1);
        if (vv_done.size() == 256) chk("full_done_last", vv_done[255], 1);
        chk("full_busy_drop", vid_busy, 0);

        // Reset during beat 3 of an 8-beat burst
        clear_logs();
        n = cyc;
        vid_req = 1; vid_addr = 16'h0233; vid_len = 8'd8;
        tick(1);
        vid_req = 0;
        tick(3);
        chk("mid_valid_before", {vid_valid, vid_data}, {1'b1, 8'h34});
        RSTn = 1'b0;
        #1;
        chk("mid_rst_maddr", maddr, 0);
        chk("mid_rst_ctl", {rwbn, rdqen, cpu_ack, vid_valid, vid_done, cpu_busy, vid_busy}, 0);
        chk("mid_rst_data", {din, cpu_rdata, vid_data}, 0);
        tick(2);
        RSTn = 1'b1;
        clear_logs();
        tick(20);
        chk("mid_no_valid", vv_dat.size(), 0);
        chk("mid_no_orphan_done", done_orphan, 0);
        chk("mid_no_reads", rd_addr.size(), 0);
        chk("mid_busy", {vid_busy, cpu_busy}, 0);

        // RD_LAT=2 instance: write then read
        clear_logs();
        n = cyc;
        c2_req = 1; c2_we = 1; c2_addr = 16'h0777; c2_wdata = 8'hA5;
        tick(1);
        c2_req = 0;
        tick(4);
        chk("l2_wr_ack_count", ack2_cyc.size(), 1);
        if (ack2_cyc.size() > 0) chk("l2_wr_ack_cycle", ack2_cyc[0], n + 2);
        clear_logs();
        n = cyc;
        c2_req = 1; c2_we = 0; c2_addr = 16'h0777; c2_wdata = 8'h00;
        tick(1);
        c2_req = 0;
        tick(7);
        chk("l2_rd_ack_count", ack2_cyc.size(), 1);
        if (ack2_cyc.size() > 0) begin
            chk("l2_rd_ack_cycle", ack2_cyc[0], n + 4);
            chk("l2_rd_data", ack2_dat[0], 8'hA5);
        end
        chk("l2_busy_drop", c2_busy, 0);

        chk("no_rw_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
